// File: rtl/uart_rx_defs.sv
// Shared definitions for the AHB-attached UART receiver.
//   - AHB register word indices (HADDR[3:2])
//   - STATUS bit positions
//   - receiver FSM state encoding (PARITY only exists when UART_RX_PARITY_EN is defined)
package uart_rx_defs;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_FERR   = 3;
  localparam int STAT_PERR   = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } rx_state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^d ^ p);
  endfunction
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i/wdata_i : write a byte (ignored when full)
//   pop_i          : remove head (ignored when empty)
//   rdata_o        : current head byte
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored bytes (AW+1 bits)
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ahb.sv
// AHB-Lite slave UART receiver (16x oversampling, 8N1; 8E1 when UART_RX_PARITY_EN is defined).
//   HCLK, HRESET                 : clock, asynchronous active-high reset
//   HSEL/HADDR/HTRANS/HSIZE/
//   HWRITE/HREADY/HWDATA         : AHB-Lite slave inputs (HADDR[3:2] decoded, HSIZE ignored)
//   HREADYOUT, HRESP, HRDATA     : AHB-Lite slave outputs (zero wait state, always OKAY)
//   RXD                          : asynchronous serial input, idles high
//   irq                          : registered level interrupt
//   dbg_state_o                  : receiver FSM state
// Registers: 0x0 DATA (RO, pops), 0x4 STATUS (W1C on [4:2]), 0x8 BAUDDIV, 0xC reads 0.
// Bus handshake: an access is accepted when HSEL & HTRANS[1] & HREADY in its address
// phase and always completes in the following cycle (HREADYOUT is constant 1).
module uart_rx_ahb
  import uart_rx_defs::*;
#(
  parameter logic [15:0] BAUD_DIV_RST = 16'd21,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [11:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  input  logic        RXD,
  output logic        irq,
  output logic [2:0]  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- bus front end ----------------
  logic       dp_valid_q, dp_write_q;
  logic [1:0] dp_addr_q;
  logic       wr_status, wr_baud, rd_data;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else begin
      dp_valid_q <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        dp_write_q <= HWRITE;
        dp_addr_q  <= HADDR[3:2];
      end
    end
  end

  assign wr_status = dp_valid_q & dp_write_q & (dp_addr_q == REG_STATUS);
  assign wr_baud   = dp_valid_q & dp_write_q & (dp_addr_q == REG_BAUD);
  assign rd_data   = dp_valid_q & ~dp_write_q & (dp_addr_q == REG_DATA);

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // ---------------- baud tick ----------------
  logic [15:0] baud_q, baud_cnt_q, baud_cnt_d;
  logic        tick;

  assign tick = (baud_cnt_q == baud_q);

  always_comb begin
    baud_cnt_d = baud_cnt_q + 16'd1;
    if (wr_baud || tick) baud_cnt_d = '0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      baud_q     <= BAUD_DIV_RST;
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      if (wr_baud) baud_q <= HWDATA[15:0];
    end
  end

  // ---------------- RXD synchronizer ----------------
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // ---------------- receiver FSM ----------------
  rx_state_e state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       push_q, push_d;
  logic       ferr_set;
`ifdef UART_RX_PARITY_EN
  logic       bad_par_q, bad_par_d;
  logic       perr_set;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    push_d     = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par_d  = bad_par_q;
    perr_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rxd_prev_q & ~rxd_s2_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          bad_par_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            // Mid start bit: a high line means the edge was a glitch.
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxd_s2_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            shreg_d    = {rxd_s2_q, shreg_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            state_d    = S_STOP;
            if (!even_parity_ok(shreg_q, rxd_s2_q)) begin
              perr_set  = 1'b1;
              bad_par_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (!rxd_s2_q) ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (!bad_par_q) push_d = 1'b1;
`else
            else push_d = 1'b1;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      push_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_par_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      push_q     <= push_d;
`ifdef UART_RX_PARITY_EN
      bad_par_q  <= bad_par_d;
`endif
    end
  end

  assign dbg_state_o = state_q;

  // ---------------- FIFO ----------------
  // shreg_q is untouched until the next frame's data bits, so it still holds
  // the byte in the cycle after the stop sample when push_q fires.
  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [AW:0] fifo_count;

  assign fifo_pop = rd_data & ~fifo_empty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push_q),
    .wdata_i (shreg_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- sticky status and irq ----------------
  logic [2:0] clr;
  logic       ovr_q, ferr_q, perr_w;
  logic       irq_q;
  logic [4:0] status_w;

  assign clr = wr_status ? HWDATA[4:2] : 3'b000;

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) perr_q <= 1'b0;
    else        perr_q <= perr_set | (perr_q & ~clr[2]);
  end
  assign perr_w = perr_q;
`else
  assign perr_w = 1'b0;
`endif

  // A set event in the same cycle as a clear wins.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr_q  <= (push_q & fifo_full) | (ovr_q & ~clr[0]);
      ferr_q <= ferr_set | (ferr_q & ~clr[1]);
      irq_q  <= ~fifo_empty | ovr_q | ferr_q | perr_w;
    end
  end

  assign irq = irq_q;

  always_comb begin
    status_w              = '0;
    status_w[STAT_NEMPTY] = ~fifo_empty;
    status_w[STAT_FULL]   = fifo_full;
    status_w[STAT_OVR]    = ovr_q;
    status_w[STAT_FERR]   = ferr_q;
    status_w[STAT_PERR]   = perr_w;
  end

  // ---------------- read data (data phase) ----------------
  always_comb begin
    HRDATA = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        REG_DATA:   HRDATA = fifo_empty ? 32'd0 : {24'd0, fifo_rdata};
        REG_STATUS: HRDATA = {27'd0, status_w};
        REG_BAUD:   HRDATA = {16'd0, baud_q};
        default:    HRDATA = '0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[11:4], HADDR[1:0], HTRANS[0], HWDATA[31:16], fifo_count};

endmodule

// File: tb/tb_uart_rx_ahb.sv
`timescale 1ns/1ps
module tb_uart_rx_ahb;
  import uart_rx_defs::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        HSEL = 1'b0;
  logic [11:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT, HRESP, irq;
  logic [31:0] HRDATA;
  logic        RXD = 1'b1;
  logic [2:0]  dbg_state_o;

  always #5 HCLK = ~HCLK;

  uart_rx_ahb #(.BAUD_DIV_RST(16'd21), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .RXD(RXD), .irq(irq),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard / model ----------------
  logic [7:0]  exp_q[$];
  logic        m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
  int          m_div = 21;
  int          n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (exp_q.size() != 0);
    s[1] = (exp_q.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_ferr;
    s[4] = m_perr;
    return s;
  endfunction

  function automatic logic model_irq();
    return (exp_q.size() != 0) | m_ovr | m_ferr | m_perr;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] r);
    logic [31:0] v;
    v = '0;
    case (r)
      2'd0: if (exp_q.size() != 0) v = {24'd0, exp_q.pop_front()};
      2'd1: v = model_status();
      2'd2: v = m_div;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  logic        rd_chk = 1'b0, irq_chk = 1'b0, st_chk = 1'b0;
  logic [31:0] rd_exp = '0;
  logic        irq_exp = 1'b0;
  logic [2:0]  st_exp = '0;
  string       rd_name = "";

  always @(negedge HCLK) begin
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("hresp", {31'd0, HRESP}, 32'd0);
    if (rd_chk)  check(rd_name, HRDATA, rd_exp);
    if (irq_chk) check("irq", {31'd0, irq}, {31'd0, irq_exp});
    if (st_chk)  check("fsm_state", {29'd0, dbg_state_o}, {29'd0, st_exp});
  end

  // ---------------- driver tasks ----------------
  task automatic ahb_read(input logic [1:0] r, input string name, output logic [31:0] got);
    logic [31:0] e;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {8'd0, r, 2'b00};
    e = model_read(r);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    rd_exp = e; rd_name = name; rd_chk = 1'b1;
    @(negedge HCLK);
    got = HRDATA;
    @(posedge HCLK); #1;
    rd_chk = 1'b0;
  endtask

  task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {8'd0, r, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
    HWDATA = '0;
    if (r == 2'd1) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
      if (d[4]) m_perr = 1'b0;
    end
    if (r == 2'd2) m_div = int'(d[15:0]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    int bt;
    bt = 16 * (m_div + 1);
    @(posedge HCLK); #1;
    RXD = 1'b0; repeat (bt) @(posedge HCLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i]; repeat (bt) @(posedge HCLK);
    end
`ifdef UART_RX_PARITY_EN
    RXD = (^b) ^ par_flip; repeat (bt) @(posedge HCLK);
`endif
    RXD = stop_bit; repeat (bt) @(posedge HCLK);
    RXD = 1'b1; repeat (bt) @(posedge HCLK);
`ifdef UART_RX_PARITY_EN
    if (!stop_bit) m_ferr = 1'b1;
    else if (par_flip) m_perr = 1'b1;
    else if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(b);
`else
    if (!stop_bit) m_ferr = 1'b1;
    else if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(b);
`endif
  endtask

  task automatic check_irq();
    repeat (3) @(posedge HCLK); #1;
    irq_exp = model_irq(); irq_chk = 1'b1;
    @(posedge HCLK); #1;
    irq_chk = 1'b0;
  endtask

  task automatic check_state(input logic [2:0] s);
    @(posedge HCLK); #1;
    st_exp = s; st_chk = 1'b1;
    @(posedge HCLK); #1;
    st_chk = 1'b0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
    summary();
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    int bt;
    bit found;

    // reset state
    #2 HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {29'd0, dbg_state_o}, {29'd0, S_IDLE});
    @(posedge HCLK); #1 HRESET = 1'b0;
    ahb_read(2'd1, "rst_status", got);
    check("rst_status_lit", got, 32'd0);
    ahb_read(2'd2, "rst_bauddiv", got);
    check("rst_bauddiv_lit", got, 32'd21);
    ahb_read(2'd3, "reserved", got);

    // two bytes at the reset divider
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    ahb_read(2'd1, "status_2b", got);
    check("status_2b_lit", got, 32'h1);
    check_irq();
    ahb_read(2'd0, "data0", got);
    check("data0_lit", got, 32'h55);
    ahb_read(2'd0, "data1", got);
    check("data1_lit", got, 32'hA3);
    ahb_read(2'd1, "status_empty", got);
    check("status_empty_lit", got, 32'h0);
    check_irq();

    // faster divider for the rest
    ahb_write(2'd2, 32'd3);
    ahb_read(2'd2, "bauddiv_wr", got);
    check("bauddiv_wr_lit", got, 32'd3);

    // short low glitch: 3 ticks
    @(posedge HCLK); #1 RXD = 1'b0;
    repeat (3 * (m_div + 1)) @(posedge HCLK);
    #1 RXD = 1'b1;
    repeat (2 * 16 * (m_div + 1)) @(posedge HCLK);
    check_state(S_IDLE);
    ahb_read(2'd1, "status_glitch", got);
    check("status_glitch_lit", got, 32'h0);

    // overflow: 17 bytes, no reads
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
    ahb_read(2'd1, "status_ovf", got);
    check("status_full_ovr_lit", {30'd0, got[2:1]}, 32'd3);
    for (int i = 0; i < 16; i++) begin
      ahb_read(2'd0, "data_ovf", got);
      check("data_ovf_lit", got, 32'(i));
    end
    ahb_read(2'd1, "status_ovf_drained", got);
    ahb_read(2'd0, "data_empty", got);
    check("data_empty_lit", got, 32'd0);
    ahb_write(2'd1, 32'h4);
    ahb_read(2'd1, "status_ovr_clr", got);

    // framing error
    send_frame(8'h3C, 1'b0, 1'b0);
    ahb_read(2'd1, "status_ferr", got);
    check("status_ferr_lit", got, 32'h8);
    check_irq();
    ahb_write(2'd1, 32'h8);
    check_irq();
    ahb_read(2'd1, "status_ferr_clr", got);

    // pop coincident with push while holding four bytes
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    bt = 16 * (m_div + 1);
    fork
      send_frame(8'h5A, 1'b1, 1'b0);
      begin
        found = 1'b0;
        for (int c = 0; c < 20 * bt && !found; c++) begin
          @(negedge HCLK);
          if (dbg_state_o == S_STOP) found = 1'b1;
        end
        check("wait_stop", {31'd0, found}, 32'd1);
        repeat (bt - 2) @(posedge HCLK);
        ahb_read(2'd0, "data_coincident", got);
        check("data_coincident_lit", got, 32'h11);
      end
    join
    for (int i = 0; i < 4; i++) ahb_read(2'd0, "data_after_coincident", got);
    ahb_read(2'd1, "status_after_coincident", got);
    check("status_after_coincident_lit", got, 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with odd parity
    send_frame(8'h07, 1'b1, 1'b1);
    ahb_read(2'd1, "status_perr", got);
    check("status_perr_lit", got, 32'h10);
    check_irq();
    ahb_write(2'd1, 32'h10);
    ahb_read(2'd1, "status_perr_clr", got);
`endif

    // reset in the middle of a frame
    send_frame(8'h66, 1'b1, 1'b0);
    @(posedge HCLK); #1 RXD = 1'b0;
    repeat (5 * bt) @(posedge HCLK);
    #3 HRESET = 1'b1;
    exp_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_div = 21;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    RXD = 1'b1;
    check_state(S_IDLE);
    repeat (12 * 16 * 22) @(posedge HCLK);
    ahb_read(2'd1, "status_midreset", got);
    check("status_midreset_lit", got, 32'h0);
    ahb_read(2'd2, "bauddiv_midreset", got);
    check_irq();

    summary();
    $finish;
  end

endmodule

// File: doc/uart_rx_ahb.md
UART_RX_AHB -- requirements
Module: uart_rx_ahb

Interface
REQ-001 SHALL have parameter BAUD_DIV_RST, default 16'd21, giving the reset value of BAUDDIV (40 MHz / (16 × 115200) − 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the receive FIFO depth, a power of 2 ≥ 2.
REQ-003 SHALL use one clock and an asynchronously asserted, active-high reset.
REQ-004 HCLK  in  1  AHB/system clock (40 MHz); all logic on its rising edge.
REQ-005 HRESET  in  1  asynchronous active-high reset.
REQ-006 HSEL  in  1  slave select.
REQ-007 HADDR  in  12  byte address; only [3:2] decoded.
REQ-008 HTRANS  in  2  transfer type; valid when HTRANS[1]=1.
REQ-009 HSIZE  in  3  ignored; all accesses are treated as 32-bit.
REQ-010 HWRITE  in  1  1=write.
REQ-011 HREADY  in  1  bus ready; address phase is taken only when high.
REQ-012 HWDATA  in  32  write data, data phase.
REQ-013 HREADYOUT  out  1  tied 1.
REQ-014 HRESP  out  1  tied 0 (OKAY).
REQ-015 HRDATA  out  32  read data, data phase.
REQ-016 RXD  in  1  asynchronous serial input; idles high.
REQ-017 irq  out  1  level interrupt.

Function
REQ-018 Address phase: when HSEL&HTRANS[1]&HREADY, register HADDR[3:2] and HWRITE; the access completes in the next cycle with zero wait states.
REQ-019 Register map:
- 0x0 DATA (RO): [7:0] = FIFO head, upper bits 0.
- 0x4 STATUS: [0] not-empty, [1] full, [2] OVR, [3] FERR, [4] PERR; bits [4:2] are sticky and cleared by writing 1.
- 0x8 BAUDDIV (RW): [15:0].
- 0xC: reads 0.
REQ-020 A DATA read pops the FIFO in its data-phase cycle; HRDATA shows the pre-pop head. A DATA read while empty returns 0 and does not pop.
REQ-021 RXD SHALL pass through a 2-flop synchronizer before use.
REQ-022 Tick generator: a 16-bit counter issues one tick every BAUDDIV+1 cycles, giving 16 ticks per bit. A write to BAUDDIV reloads the counter.
REQ-023 FSM states IDLE, START, DATA, PARITY, STOP:
- IDLE→START on a synchronized falling edge.
- START: at tick 7, a low sample → DATA; a high sample → IDLE (glitch reject).
- DATA: sample every 16 ticks at mid-bit, 8 bits, LSB first.
- After 8 bits → PARITY if enabled, else STOP.
- STOP: sample at mid-bit, then → IDLE.
REQ-024 Stop sample = 0 sets FERR, and the byte is discarded.
REQ-025 A valid byte is pushed one cycle after the stop sample. If the FIFO is full, the byte is dropped and OVR is set.
REQ-026 A push and pop in the same cycle both take effect; the count is unchanged.
REQ-027 FIFO pointers use a width of log2(FIFO_DEPTH) and wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits wide.
REQ-028 irq = not-empty | OVR | FERR | PERR, registered (one cycle after the cause).
REQ-029 A sticky-bit clear coincident with a new error event leaves that bit set (set wins).

Reset
REQ-030 On HRESET SHALL set:
- FSM to IDLE; FIFO empty.
- STATUS sticky bits to 0; BAUDDIV to BAUD_DIV_RST.
- HRDATA to 0, irq to 0.
- Synchronizer flops to 1.
REQ-031 HRESET asserted mid-frame SHALL abandon the frame, and no byte is pushed.

Configuration
REQ-032 Macro UART_RX_PARITY_EN SHALL control parity checking:
- Defined: PARITY state present and even parity checked; a mismatch sets PERR and discards the byte.
- Undefined: no PARITY state, STATUS[4] reads 0, and the frame format is 8N1.

Structure
REQ-033 Register offsets, STATUS bit indices and FSM state encodings SHALL live in a shared package uart_rx_defs.
REQ-034 The FIFO SHALL be a sub-module uart_rx_fifo with push/pop/full/empty/count ports.

Verification
REQ-035 Bytes 0x55, 0xA3 at BAUDDIV=21 (8N1) → STATUS=0x1, DATA reads 0x55 then 0xA3, then STATUS=0x0.
REQ-036 17 bytes with no reads (depth 16) → STATUS[1]=1 and OVR=1; 16 reads return bytes 0..15, and the 17th byte is lost.
REQ-037 A 3-tick low pulse on RXD → no push, FSM back to IDLE, STATUS=0.
REQ-038 Frame with stop bit 0 → FERR=1, irq=1, FIFO empty; writing 0x8 to STATUS → FERR=0, irq=0 next cycle.
REQ-039 With UART_RX_PARITY_EN defined, 0x07 sent with odd parity → PERR=1 and no push; HRESET mid-byte → no push and all STATUS bits 0.
REQ-040 DATA pop coincident with a push when the FIFO holds 4 bytes → count stays 4, and the read returns the old head.
